// File: rtl/pipe_pkg.sv
// Shared constants for the ID->EX pipeline register: control-bit positions,
// payload field layout and the occupancy state encoding.
package pipe_pkg;

  localparam int CTRL_W      = 9;
  localparam int ALUSRC_BIT  = 5;
  localparam int MEMREAD_BIT = 2;
  localparam int BRANCH_BIT  = 1;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int ALUCTRL_W = 2;

  // Payload layout, LSB first: rd1, rd2, imm/addr, pc, rs, rt, rd, aluCtrl
  localparam int RD1_OFF     = 0;
  localparam int RD2_OFF     = RD1_OFF + DATA_W;
  localparam int ADDR_OFF    = RD2_OFF + DATA_W;
  localparam int PC_OFF      = ADDR_OFF + DATA_W;
  localparam int RS_OFF      = PC_OFF + DATA_W;
  localparam int RT_OFF      = RS_OFF + REG_W;
  localparam int RD_OFF      = RT_OFF + REG_W;
  localparam int ALUCTRL_OFF = RD_OFF + REG_W;
  localparam int PAYLOAD_W   = ALUCTRL_OFF + ALUCTRL_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/id_ex_skid_slot.sv
// One pipeline entry: valid + control + payload. Clear drops the entry and
// zeroes its control bits but leaves the payload untouched.
module id_ex_skid_slot #(
  parameter int CTRL_W    = 9,
  parameter int PAYLOAD_W = 145
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CTRL_W-1:0]    d_ctrl,
  input  logic [PAYLOAD_W-1:0] d_payload,
  output logic                 valid_q,
  output logic [CTRL_W-1:0]    ctrl_q,
  output logic [PAYLOAD_W-1:0] payload_q
);

  logic                 valid_d;
  logic [CTRL_W-1:0]    ctrl_d;
  logic [PAYLOAD_W-1:0] payload_d;

  // Next entry contents; clear has priority over load
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    payload_d = payload_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d   = 1'b1;
      ctrl_d    = d_ctrl;
      payload_d = d_payload;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush-to-bubble and,
// when ID_EX_SKID_EN is defined, a second skid entry with a registered in_ready.
module id_ex_pipe_stage #(
  parameter int CTRL_W      = pipe_pkg::CTRL_W,
  parameter int PAYLOAD_W   = pipe_pkg::PAYLOAD_W,
  parameter int ALUSRC_BIT  = pipe_pkg::ALUSRC_BIT,
  parameter int MEMREAD_BIT = pipe_pkg::MEMREAD_BIT,
  parameter int BRANCH_BIT  = pipe_pkg::BRANCH_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_alu_src,
  output logic                 out_mem_read,
  output logic                 out_branch,
  output logic [1:0]           out_occupancy
);

  import pipe_pkg::*;

  state_e               state_q, state_d;
  logic                 in_fire, out_fire;
  logic                 main_load, main_clear;
  logic                 main_valid_q;
  logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
  logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

`ifdef ID_EX_SKID_EN
  logic                 skid_load, skid_clear;
  logic                 skid_valid_q;
  logic [CTRL_W-1:0]    skid_ctrl_q;
  logic [PAYLOAD_W-1:0] skid_payload_q;
  logic                 in_ready_q, in_ready_d;
`endif

  // Occupancy transitions; flush empties the stage and wins over any in-fire
  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
`ifdef ID_EX_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
`ifdef ID_EX_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end else if (in_fire) begin
`ifdef ID_EX_SKID_EN
            skid_load = 1'b1;
            state_d   = ST_TWO;
`else
            main_load = 1'b1;
            state_d   = ST_ONE;
`endif
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
`ifdef ID_EX_SKID_EN
          // Skid (younger) entry advances into main on the same edge
          if (out_fire) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
`else
          main_clear = 1'b1;
          state_d    = ST_EMPTY;
`endif
        end
        default: begin
          main_clear = 1'b1;
`ifdef ID_EX_SKID_EN
          skid_clear = 1'b1;
`endif
          state_d    = ST_EMPTY;
        end
      endcase
    end
  end

  // Main entry source: the skid entry when draining from TWO, else decode
  always_comb begin
`ifdef ID_EX_SKID_EN
    if (state_q == ST_TWO) begin
      main_ctrl_d    = skid_ctrl_q;
      main_payload_d = skid_payload_q;
    end else begin
      main_ctrl_d    = in_ctrl;
      main_payload_d = in_payload;
    end
`else
    main_ctrl_d    = in_ctrl;
    main_payload_d = in_payload;
`endif
  end

  // Occupancy state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  id_ex_skid_slot #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_main (
    .clock     (clock),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .d_ctrl    (main_ctrl_d),
    .d_payload (main_payload_d),
    .valid_q   (main_valid_q),
    .ctrl_q    (main_ctrl_q),
    .payload_q (main_payload_q)
  );

`ifdef ID_EX_SKID_EN
  id_ex_skid_slot #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .d_ctrl    (in_ctrl),
    .d_payload (in_payload),
    .valid_q   (skid_valid_q),
    .ctrl_q    (skid_ctrl_q),
    .payload_q (skid_payload_q)
  );

  assign in_ready_d = (state_d != ST_TWO);

  // Registered ready breaks the out_ready -> in_ready path
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  assign in_ready      = out_ready | ~main_valid_q;
  assign out_occupancy = {1'b0, main_valid_q};
`endif

  // A bubble never presents live control bits to execute
  always_comb begin
    if (main_valid_q) begin
      out_ctrl = main_ctrl_q;
    end else begin
      out_ctrl = '0;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_payload  = main_payload_q;
  assign out_alu_src  = out_ctrl[ALUSRC_BIT];
  assign out_mem_read = out_ctrl[MEMREAD_BIT];
  assign out_branch   = out_ctrl[BRANCH_BIT];

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: directed scenarios followed by random
// traffic, checked against a FIFO-of-capacity model (1 entry, or 2 with ID_EX_SKID_EN).
module tb_id_ex_pipe_stage;

  localparam int CW = 9;
  localparam int PW = 145;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [PW-1:0] payload;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [PW-1:0] in_payload, out_payload;
  logic          out_alu_src, out_mem_read, out_branch;
  logic [1:0]    out_occupancy;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  logic last_rst = 1'b1;

  id_ex_pipe_stage dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_payload    (in_payload),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_payload   (out_payload),
    .out_alu_src   (out_alu_src),
    .out_mem_read  (out_mem_read),
    .out_branch    (out_branch),
    .out_occupancy (out_occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare mid-cycle, then apply the coming edge to the model
  initial begin
    ent_t head;
    logic exp_ready;
    forever begin
      @(negedge clock);
      if (q.size() < CAP) exp_ready = 1'b1;
      else if (CAP == 1)  exp_ready = out_ready;
      else                exp_ready = 1'b0;
      if (last_rst) begin
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_out_ctrl", 160'(out_ctrl), 160'(0));
        check("rst_payload", 160'(out_payload), 160'(0));
        check("rst_occupancy", 160'(out_occupancy), 160'(0));
        check("rst_in_ready", 160'(in_ready), 160'(1));
        check("rst_decoded", 160'({out_alu_src, out_mem_read, out_branch}), 160'(0));
      end else begin
        check("out_valid", 160'(out_valid), 160'(q.size() != 0));
        check("occupancy", 160'(out_occupancy), 160'(q.size()));
        check("in_ready", 160'(in_ready), 160'(exp_ready));
        if (q.size() != 0) begin
          head = q[0];
          check("head_ctrl", 160'(out_ctrl), 160'(head.ctrl));
          check("head_payload", 160'(out_payload), 160'(head.payload));
          check("decoded", 160'({out_alu_src, out_mem_read, out_branch}),
                160'({head.ctrl[5], head.ctrl[2], head.ctrl[1]}));
        end else begin
          check("bubble_ctrl", 160'(out_ctrl), 160'(0));
          check("bubble_decoded", 160'({out_alu_src, out_mem_read, out_branch}), 160'(0));
        end
      end
      if (reset) begin
        q.delete();
        last_rst = 1'b1;
      end else begin
        last_rst = 1'b0;
        if (flush) begin
          q.delete();
        end else begin
          if (q.size() != 0 && out_ready) void'(q.pop_front());
          if (in_valid && exp_ready) q.push_back({in_ctrl, in_payload});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [CW-1:0] c, input logic [PW-1:0] p);
    in_valid   = v;
    out_ready  = r;
    flush      = f;
    in_ctrl    = c;
    in_payload = p;
    step();
  endtask

  initial begin
    logic [159:0] wide;
    logic [31:0]  rc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 9'h1FF; in_payload = '0;
    repeat (3) step();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 9'h0A6, 145'd100);
    // Back-to-back stream of eight
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 9'(i * 37), 145'(i));
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    // Stall with decode still pushing, then flush the full stage
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 9'h124, 145'(16'hB00 + i));
    drive(1'b1, 1'b1, 1'b1, 9'h1FF, 145'h777);
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    // Decoded control bits, then a bubble
    drive(1'b1, 1'b1, 1'b0, 9'b000100100, 145'hABC);
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    // Simultaneous in/out fire while holding one entry
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 9'(i + 2), 145'(16'hC00 + i));
    drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    for (int i = 0; i < 1500; i++) begin
      wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rc   = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, rc[CW-1:0], wide[PW-1:0]);
    end
    // Reset in the middle of traffic, with flush also raised
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 9'h1FF, 145'h1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 9'h000, 145'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
